// File: rtl/uart_pkg.sv
// Types and sizes shared by the UART receive and transmit managers.
package uart_pkg;
    localparam int QUEUE_DEPTH = 512;
    localparam int QPTR_W      = $clog2(QUEUE_DEPTH);

    typedef logic [QPTR_W-1:0] qptr_t;
    typedef logic [7:0]        byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;
endpackage

// File: rtl/input_manager_receiver.sv
// 8N1 UART deserialiser: 2-FF synchroniser plus bit-timing FSM.
// With RX_FRAME_CHECK_EN defined, a low stop bit drops the byte and raises stop_err.
module input_manager_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  rx,
    output byte_t data,
    output logic  byte_valid,
    output logic  stop_err,
    output logic  busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta_q;
    logic             rx_s_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    byte_t            data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        data_d     = data_q;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d         = '0;
                    data_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                // Leaving at mid stop bit keeps back-to-back frames aligned.
                if (cnt_q == FULL_CNT) begin
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef RX_FRAME_CHECK_EN
                    if (rx_s_q) begin
                        byte_valid = 1'b1;
                    end else begin
                        stop_err = 1'b1;
                    end
`else
                    byte_valid = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data = data_q;
    assign busy = (state_q != IDLE);
endmodule

// File: rtl/input_manager.sv
// UART receive queue: 512-entry byte ring written by the deserialiser, read by the core.
// RX_FRAME_CHECK_EN enables stop-bit checking and the frame_err flag.
module input_manager
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              CLK,
    input  logic              INITIALIZE_N,
    input  logic              UART_RX,
    input  logic [QPTR_W-1:0] queue_s,
    output logic [7:0]        rd_data,
    output logic [QPTR_W-1:0] queue_t,
    output logic              overrun,
    output logic              frame_err,
    output logic [7:0]        LED
);
    byte_t rx_data;
    logic  byte_valid;
    logic  stop_err;
    logic  rx_busy;

    input_manager_receiver #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_receiver (
        .clk       (CLK),
        .rst_n     (INITIALIZE_N),
        .rx        (UART_RX),
        .data      (rx_data),
        .byte_valid(byte_valid),
        .stop_err  (stop_err),
        .busy      (rx_busy)
    );

    byte_t mem [QUEUE_DEPTH];

    qptr_t queue_t_q, queue_t_d;
    logic  overrun_q, overrun_d;
    logic  frame_err_q, frame_err_d;
    logic  led_toggle_q, led_toggle_d;
    byte_t rd_data_q;
    logic  full;
    logic  wr_en;

    // One slot is kept empty so that queue_s == queue_t always means empty.
    assign full  = (qptr_t'(queue_t_q + 1'b1) == queue_s);
    assign wr_en = byte_valid && !full;

    always_comb begin
        queue_t_d    = queue_t_q;
        overrun_d    = overrun_q;
        frame_err_d  = frame_err_q | stop_err;
        led_toggle_d = led_toggle_q;
        if (byte_valid) begin
            if (full) begin
                overrun_d = 1'b1;
            end else begin
                queue_t_d    = queue_t_q + 1'b1;
                led_toggle_d = ~led_toggle_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge INITIALIZE_N) begin
        if (!INITIALIZE_N) begin
            queue_t_q    <= '0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            led_toggle_q <= 1'b0;
        end else begin
            queue_t_q    <= queue_t_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
            led_toggle_q <= led_toggle_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[queue_t_q] <= rx_data;
        end
    end

    // Read-before-write on a same-address collision; harmless since the
    // consumer never reads at queue_t.
    always_ff @(posedge CLK or negedge INITIALIZE_N) begin
        if (!INITIALIZE_N) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[queue_s];
        end
    end

    assign rd_data   = rd_data_q;
    assign queue_t   = queue_t_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign LED       = {led_toggle_q, 4'b0000, rx_busy, frame_err_q, overrun_q};
endmodule

// File: doc/input_manager.md
Name: input_manager

Overview:
- Receive-side counterpart of the UART transmit path.
- Deserialises 8N1 frames from UART_RX and writes each byte into a 512-entry receive queue.
- Publishes the write pointer queue_t. The core consumes bytes by advancing its read pointer queue_s.
- Sits between the board UART pin and the core's input instruction logic.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 4.
- QUEUE_DEPTH, 512, receive queue entries; fixed power of two; pointer width = $clog2(QUEUE_DEPTH) = 9.

Ports:
- CLK  in  1  system clock
- INITIALIZE_N  in  1  asynchronous active-low reset
- UART_RX  in  1  serial line, idle high, asynchronous to CLK
- queue_s  in  9  consumer read pointer; next entry the core will read
- rd_data  out  8  queue entry at queue_s, registered
- queue_t  out  9  write pointer; queue non-empty iff queue_s != queue_t
- overrun  out  1  sticky: a byte was dropped because the queue was full
- frame_err  out  1  sticky: a stop bit was sampled low (see Optional Feature)
- LED  out  8  debug indicators

Behaviour:
- Reset (INITIALIZE_N low, async assert, sync deassert handled upstream):
  - queue_t=0, overrun=0, frame_err=0, LED=0, rd_data=0.
  - Sync flops=1; FSM=IDLE; bit counter=0, bit index=0.
  - Queue memory contents are not reset.
- Reset mid-frame abandons the frame. After release the FSM waits for the next falling edge.
- Input sync: UART_RX passes through a 2-FF synchroniser (reset value 1). rx_s is the second stage; the FSM uses only rx_s.
- FSM states:
  - IDLE: rx_s==0 -> START, cnt=0.
  - START: at cnt==CLKS_PER_BIT/2-1, if rx_s==0 -> DATA (cnt=0, idx=0); otherwise glitch, return to IDLE with no write.
  - DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into bit idx (LSB first) and clear cnt. After idx 7 -> STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample the stop bit, pulse byte_valid for 1 cycle, go to IDLE.
  - The FSM returns to IDLE at mid stop bit, so back-to-back frames are accepted.
- Queue write, in the cycle byte_valid=1:
  - Not full, where full ⇔ queue_t+1 (mod 512) == queue_s: mem[queue_t] <= byte; queue_t <= queue_t+1.
  - queue_t wraps 511->0 by 9-bit overflow. Usable capacity is 511 bytes.
  - Full: byte discarded, queue_t unchanged, overrun <= 1.
  - overrun and frame_err are sticky until reset.
- Latency: queue_t updates 1 cycle after the mid stop-bit sample.
- Read port: rd_data <= mem[queue_s] every cycle, giving 1-cycle latency (BRAM-inferable).
  - Same-cycle write to address queue_s: rd_data returns the old contents. The consumer must not read an entry until queue_t has passed it, so this case is benign.
- queue_s is sampled only for the full check. Any queue_s change takes effect for the next byte_valid.
- LED:
  - LED[0]=overrun, LED[1]=frame_err.
  - LED[2] = FSM != IDLE.
  - LED[7] toggles on each byte committed to the queue.
  - LED[6:3]=0.

Optional Feature:
- Macro: RX_FRAME_CHECK_EN.
- Defined: a stop bit sampled 0 suppresses byte_valid, so nothing is written and queue_t is unchanged; frame_err <= 1.
- Undefined: the stop bit is ignored, the byte is always offered to the queue, and frame_err is tied 0.

Decomposition:
- Shared package uart_pkg:
  - localparam QUEUE_DEPTH=512 and QPTR_W=9.
  - typedef logic[QPTR_W-1:0] qptr_t.
  - typedef logic[7:0] byte_t.
  - enum rx_state_t {IDLE, START, DATA, STOP}.
  - These are shared with the transmit-side manager.
- Sub-module receiver: synchroniser + FSM, producing byte_t data and a byte_valid pulse. It is the mirror of the existing sender.
- input_manager holds the queue memory, pointers and flags.

Test Plan (CLKS_PER_BIT=16):
1. Send 0x55 then 0xA3 back-to-back, queue_s=0 -> queue_t steps 0->1->2; entry 0=0x55, entry 1=0xA3; overrun=0; LED[7] toggles twice.
2. Pull UART_RX low for 4 cycles, then high -> no write, queue_t unchanged, FSM back in IDLE.
3. queue_s=0, send 512 bytes 0x00..0xFF repeating -> queue_t=511 after 511 bytes; byte 512 dropped; overrun=1. Then set queue_s=10 and send 0x7E -> mem[511]=0x7E, queue_t wraps to 0.
4. Stop bit driven low on byte 0x42 -> with RX_FRAME_CHECK_EN: queue_t unchanged, frame_err=1. Without it: 0x42 written, frame_err=0.
5. Assert INITIALIZE_N low mid-DATA of a frame -> all outputs zero immediately. After release the partial frame is not written, and the next full frame 0x31 lands at entry 0.
6. queue_s steps 0,1 while entries hold 0x55,0xA3 -> rd_data shows 0x55, then 0xA3, each one cycle after queue_s changes.
